// File: rtl/holder_filter.sv
// -----------------------------------------------------------------------------
// holder_filter
//
// Holds a WIDTH-bit value on Out. Every cycle the block samples A and counts
// how many consecutive edges A has stayed the same. Sel chooses, per edge,
// whether Out is loaded only once A has been steady for STABLE_CYCLES edges
// (filtered capture), loaded directly, cleared, or held.
//
// Parameters:
//   WIDTH          data width of A and Out (1..32)
//   STABLE_CYCLES  consecutive equal samples needed for a filtered capture (2..16)
//
// Ports:
//   clock    rising-edge clock for all state
//   reset    synchronous active-high reset
//   A        data to be held
//   Sel      mode select: 001/101 filtered capture, 100 clear, 010 direct load,
//            anything else hold
//   Out      registered held value
//   Stable   registered stability condition of the previous edge
//   Changed  one-cycle pulse after an edge that changed Out; this port exists
//            only when HOLDER_CHANGE_FLAG_EN is defined
// -----------------------------------------------------------------------------
module holder_filter #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [2:0]       Sel,
    output logic [WIDTH-1:0] Out,
`ifdef HOLDER_CHANGE_FLAG_EN
    output logic             Changed,
`endif
    output logic             Stable
);

    localparam int             RUN_W   = $clog2(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic [WIDTH-1:0] smp_reg;
    logic [RUN_W-1:0] run_reg;
    logic [RUN_W-1:0] run_next;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;
    logic             stable_reg;
    logic             stab_cond;

    // run==0 marks "no valid sample yet", so after reset a value of A that
    // happens to match the cleared sample register is not counted as a repeat.
    always_comb begin
        stab_cond = (run_reg != '0) && (A == smp_reg) && (run_reg >= RUN_MAX);
    end

    // Run length of the current equal-sample streak, saturating so it never wraps.
    always_comb begin
        run_next = RUN_ONE;
        if (run_reg != '0 && A == smp_reg) begin
            run_next = (run_reg >= RUN_MAX) ? RUN_MAX : run_reg + RUN_ONE;
        end
    end

    always_comb begin
        out_next = out_reg;
        case (Sel)
            3'b001, 3'b101: if (stab_cond) out_next = A;
            3'b100:         out_next = '0;
            3'b010:         out_next = A;
            default:        out_next = out_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            smp_reg    <= '0;
            run_reg    <= '0;
            out_reg    <= '0;
            stable_reg <= 1'b0;
        end else begin
            smp_reg    <= A;
            run_reg    <= run_next;
            out_reg    <= out_next;
            stable_reg <= stab_cond;
        end
    end

    assign Out    = out_reg;
    assign Stable = stable_reg;

`ifdef HOLDER_CHANGE_FLAG_EN
    logic changed_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= (out_next != out_reg);
        end
    end

    assign Changed = changed_reg;
`endif

endmodule

// File: tb/tb_holder_filter.sv
// -----------------------------------------------------------------------------
// tb_holder_filter
//
// Three holder_filter instances (STABLE_CYCLES = 2, 3, 4, WIDTH = 8) share one
// clock and one set of inputs. A reference model derives the stability
// condition from the history of A since the last reset: a filtered capture is
// allowed when the current A equals each of the previous STABLE_CYCLES-1
// post-reset samples. Fixed vector tables and short hand-written sequences
// cover the documented scenarios; a random phase follows.
// -----------------------------------------------------------------------------
module tb_holder_filter;

    logic       clock;
    logic       reset;
    logic [7:0] A;
    logic [2:0] Sel;
    logic [7:0] dout    [3];
    logic       dstable [3];
`ifdef HOLDER_CHANGE_FLAG_EN
    logic       dchanged [3];
`endif

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            holder_filter #(
                .WIDTH         (8),
                .STABLE_CYCLES (gi + 2)
            ) u_dut (
                .clock   (clock),
                .reset   (reset),
                .A       (A),
                .Sel     (Sel),
                .Out     (dout[gi]),
`ifdef HOLDER_CHANGE_FLAG_EN
                .Changed (dchanged[gi]),
`endif
                .Stable  (dstable[gi])
            );
        end
    endgenerate

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks;
    int errors;

    // Reference model state
    logic [7:0] m_out     [3];
    logic       m_stable  [3];
    logic       m_changed [3];
    logic [7:0] hist [$];      // A values sampled since the last reset

    typedef struct {
        logic       rst;
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] exp_out;     // expected Out of the STABLE_CYCLES=2 instance
        logic       exp_stable;
    } vec_t;

    vec_t tbl [19];

    logic [7:0] s27_a   [7] = '{8'h33, 8'h33, 8'h34, 8'h33, 8'h33, 8'h33, 8'h33};
    logic [7:0] s27_out [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33};
    logic       s30_st  [3] = '{1'b0, 1'b0, 1'b1};

    function automatic logic model_stab(int sc, logic [7:0] a);
        int n;
        n = hist.size();
        if (n < sc - 1) return 1'b0;
        for (int i = 1; i <= sc - 1; i++) begin
            if (hist[n - i] != a) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check8(input string name, input int k, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s sc=%0d actual=%02h required=%02h t=%0t", name, k + 2, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input int k, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s sc=%0d actual=%b required=%b t=%0t", name, k + 2, act, req, $time);
        end
    endtask

    // Drive one edge's inputs, advance the model, then compare every instance.
    task automatic step(input logic r, input logic [2:0] s, input logic [7:0] a);
        logic [7:0] nxt;
        logic       st;
        reset = r;
        Sel   = s;
        A     = a;
        for (int k = 0; k < 3; k++) begin
            st  = model_stab(k + 2, a);
            nxt = m_out[k];
            if (r) begin
                nxt = 8'h00;
            end else begin
                case (s)
                    3'b001, 3'b101: if (st) nxt = a;
                    3'b100:         nxt = 8'h00;
                    3'b010:         nxt = a;
                    default:        ;
                endcase
            end
            m_changed[k] = !r && (nxt != m_out[k]);
            m_stable[k]  = !r && st;
            m_out[k]     = nxt;
        end
        if (r) begin
            hist.delete();
        end else begin
            hist.push_back(a);
            if (hist.size() > 16) void'(hist.pop_front());
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            check8("model_out", k, dout[k], m_out[k]);
            check1("model_stable", k, dstable[k], m_stable[k]);
`ifdef HOLDER_CHANGE_FLAG_EN
            check1("model_changed", k, dchanged[k], m_changed[k]);
`endif
        end
        $display("txn rst=%b sel=%03b a=%02h out=%02h/%02h/%02h stable=%b%b%b",
                 r, s, a, dout[0], dout[1], dout[2], dstable[0], dstable[1], dstable[2]);
    endtask

    initial begin
        logic       r;
        logic [2:0] s;
        logic [7:0] a;
        int         pick;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        Sel    = 3'b000;
        A      = 8'h00;
        for (int k = 0; k < 3; k++) begin
            m_out[k]     = 8'h00;
            m_stable[k]  = 1'b0;
            m_changed[k] = 1'b0;
        end

        // Vector table for the STABLE_CYCLES=2 instance.
        tbl[0]  = '{1'b1, 3'b001, 8'hAA, 8'h00, 1'b0};  // reset state
        tbl[1]  = '{1'b0, 3'b001, 8'h5A, 8'h00, 1'b0};  // first sample only
        tbl[2]  = '{1'b0, 3'b001, 8'h5A, 8'h5A, 1'b1};  // filtered capture
        tbl[3]  = '{1'b0, 3'b001, 8'h5A, 8'h5A, 1'b1};  // saturated refresh
        tbl[4]  = '{1'b0, 3'b100, 8'h5A, 8'h00, 1'b1};  // clear, Stable unaffected
        tbl[5]  = '{1'b0, 3'b000, 8'hFF, 8'h00, 1'b0};  // hold after clear
        tbl[6]  = '{1'b0, 3'b000, 8'hFF, 8'h00, 1'b1};
        tbl[7]  = '{1'b0, 3'b010, 8'h01, 8'h01, 1'b0};  // direct load toggling
        tbl[8]  = '{1'b0, 3'b010, 8'h02, 8'h02, 1'b0};
        tbl[9]  = '{1'b0, 3'b010, 8'h01, 8'h01, 1'b0};
        tbl[10] = '{1'b0, 3'b010, 8'h02, 8'h02, 1'b0};
        tbl[11] = '{1'b0, 3'b011, 8'h02, 8'h02, 1'b1};  // hold code 011
        tbl[12] = '{1'b0, 3'b101, 8'h07, 8'h02, 1'b0};  // alternate filter code
        tbl[13] = '{1'b0, 3'b101, 8'h07, 8'h07, 1'b1};
        tbl[14] = '{1'b0, 3'b110, 8'h00, 8'h07, 1'b0};  // hold code 110
        tbl[15] = '{1'b0, 3'b111, 8'h00, 8'h07, 1'b1};  // hold code 111
        tbl[16] = '{1'b1, 3'b010, 8'h00, 8'h00, 1'b0};  // reset beats direct load
        tbl[17] = '{1'b0, 3'b001, 8'h00, 8'h00, 1'b0};  // A==0 after reset is not a repeat
        tbl[18] = '{1'b0, 3'b001, 8'h00, 8'h00, 1'b1};

        step(1'b1, 3'b000, 8'h00);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, tbl[i].sel, tbl[i].a);
            check8("tbl_out", 0, dout[0], tbl[i].exp_out);
            check1("tbl_stable", 0, dstable[0], tbl[i].exp_stable);
        end

        // Glitch inside a STABLE_CYCLES=4 filter window.
        step(1'b1, 3'b101, 8'h33);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 3'b101, s27_a[i]);
            check8("glitch_out", 2, dout[2], s27_out[i]);
        end

        // Reset in the middle of a STABLE_CYCLES=3 run of zeros.
        step(1'b0, 3'b001, 8'h00);
        step(1'b0, 3'b001, 8'h00);
        step(1'b1, 3'b001, 8'h00);
        check8("midrst_out", 1, dout[1], 8'h00);
        check1("midrst_stable", 1, dstable[1], 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b001, 8'h00);
            check1("midrst_run", 1, dstable[1], s30_st[i]);
        end

`ifdef HOLDER_CHANGE_FLAG_EN
        // Changed on repeated direct loads (Out is 00 beforehand).
        step(1'b0, 3'b010, 8'h10);
        check1("chg_first", 0, dchanged[0], 1'b1);
        step(1'b0, 3'b010, 8'h10);
        check1("chg_repeat", 0, dchanged[0], 1'b0);
        step(1'b0, 3'b010, 8'h11);
        check1("chg_third", 0, dchanged[0], 1'b1);
`endif

        // Random phase: long runs of A, filtered modes favoured, rare resets.
        a = 8'h00;
        for (int i = 0; i < 400; i++) begin
            r    = ($urandom_range(0, 39) == 0);
            pick = int'($urandom_range(0, 11));
            if (pick < 8)       s = 3'(pick);
            else if (pick < 10) s = 3'b001;
            else                s = 3'b101;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       a = 8'h00;
                    1:       a = 8'h5A;
                    2:       a = 8'hFF;
                    default: a = 8'($urandom_range(0, 255));
                endcase
            end
            step(r, s, a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
